// File: rtl/plotter_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the TX state enum, default parameters and the frame length.
package plotter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DEFAULT_FIFO_DEPTH   = 8;
  localparam int FRAME_BITS           = 10;

  // Bits needed to hold max_val; never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line status bundle between a producer and uart_tx.
interface uart_tx_if
  import plotter_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx;
  logic          busy;
  logic [CW-1:0] fifo_count;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, busy, fifo_count
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, busy, fifo_count
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a first-word-fall-through head (dout is the oldest entry).
// DEPTH must be a power of two so the pointers wrap on natural overflow.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter fed from a small byte FIFO; tx is registered.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more bytes wait
module uart_tx
  import plotter_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH
) (
  input logic     clk,
  input logic     reset,
  uart_tx_if.slave bus
);

  localparam int BW = cnt_width(CLKS_PER_BIT - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  logic          fifo_push, fifo_pop;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  // Ready comes from the registered count only, so a pop never frees a slot in the same cycle.
  assign bus.tx_ready = !fifo_full && !reset;
  assign fifo_push    = bus.tx_valid && bus.tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // tx_d is the line level for the cycle after this edge, so it tracks the state being entered.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          baud_d   = '0;
          bit_d    = '0;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            bit_d    = '0;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = (state_q != IDLE) || (fifo_count != '0);
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a line decoder pops expected bytes from a scoreboard queue.
module tb_uart_tx;
  import plotter_pkg::*;

  localparam int CPB       = 4;
  localparam int DEPTH     = 8;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];
  int         cyc       = 0;
  int         rx_cnt    = 0;
  int         max_count = 0;

  bit         in_frame  = 1'b0;
  int         k_pos     = 0;
  int         bit_idx   = 0;
  bit         shape_ok  = 1'b1;
  logic [7:0] rx_byte   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line decoder: checks every cycle of the frame against the bit it belongs to.
  always @(negedge clk) begin
    cyc++;
    if (int'(bus.fifo_count) > max_count) max_count = int'(bus.fifo_count);
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (bus.tx == 1'b0) begin
        in_frame = 1'b1;
        k_pos    = 1;
        shape_ok = 1'b1;
        rx_byte  = '0;
        start_q.push_back(cyc);
      end
    end else begin
      bit_idx = k_pos / CPB;
      if (bit_idx == 0) begin
        if (bus.tx !== 1'b0) shape_ok = 1'b0;
      end else if (bit_idx <= 8) begin
        if (k_pos % CPB == 0) rx_byte[bit_idx-1] = bus.tx;
        else if (bus.tx !== rx_byte[bit_idx-1]) shape_ok = 1'b0;
      end else if (bus.tx !== 1'b1) begin
        shape_ok = 1'b0;
      end
      k_pos++;
      if (k_pos == FRAME_CYC) begin
        in_frame = 1'b0;
        rx_cnt++;
        chk("frame_shape", shape_ok, 1);
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("rx_byte", rx_byte, exp_q.pop_front());
      end
    end
  end

  // Offers b from a negedge, waits for ready, records it; returns one negedge after acceptance with valid still high.
  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.tx_ready) begin
      chk("send_ready", bus.tx_ready, 1);
      bus.tx_valid = 1'b0;
    end else begin
      exp_q.push_back(b);
      @(negedge clk);
    end
  endtask

  task automatic idle_wait(output int n);
    n = 0;
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", bus.busy, 0);
  endtask

  initial begin
    int         n;
    int         rx0;
    int         bi;
    logic       e;
    logic [7:0] v;

    bus.tx_data  = 8'hEE;
    bus.tx_valid = 1'b1;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", bus.tx, 1);
    chk("rst_ready", bus.tx_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.fifo_count, 0);
    reset        = 1'b0;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.tx_ready, 1);
    chk("count_after_rst", bus.fifo_count, 0);
    chk("busy_after_rst", bus.busy, 0);

    // Single 0x55 frame, cycle-exact
    v = 8'h55;
    send(v);
    bus.tx_valid = 1'b0;
    chk("lat_tx", bus.tx, 1);
    chk("lat_count", bus.fifo_count, 1);
    chk("lat_busy", bus.busy, 1);
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge clk);
      bi = k / CPB;
      if (bi == 0) e = 1'b0;
      else if (bi == 9) e = 1'b1;
      else e = v[bi-1];
      chk("f55_tx", bus.tx, e);
      if (k == 0) chk("f55_popped", bus.fifo_count, 0);
      if (k == FRAME_CYC - 1) chk("f55_busy_stop", bus.busy, 1);
    end
    @(negedge clk);
    chk("f55_busy_end", bus.busy, 0);
    chk("f55_tx_end", bus.tx, 1);

    // Back-to-back frames
    start_q.delete();
    send(8'hA5);
    send(8'h3C);
    bus.tx_valid = 1'b0;
    idle_wait(n);
    chk("b2b_cycles", n, 2 * FRAME_CYC);
    chk("b2b_starts", start_q.size(), 2);
    if (start_q.size() == 2) chk("b2b_gap", start_q[1] - start_q[0], FRAME_CYC);
    chk("b2b_drained", exp_q.size(), 0);

    // Fill to full, then hold a rejected byte
    rx0 = rx_cnt;
    for (int i = 0; i < 9; i++) begin
      send(8'(i));
      if (i == 1) chk("pushpop_count", bus.fifo_count, 1);
    end
    bus.tx_data = 8'hFF;
    chk("full_count", bus.fifo_count, DEPTH);
    chk("full_ready", bus.tx_ready, 0);
    n = 0;
    while (!bus.tx_ready && n < 200) begin
      chk("full_hold", bus.fifo_count, DEPTH);
      @(negedge clk);
      n++;
    end
    bus.tx_valid = 1'b0;
    chk("ready_rise", n, 33);
    chk("count_after_pop", bus.fifo_count, DEPTH - 1);
    idle_wait(n);
    chk("fill_rx", rx_cnt - rx0, 9);
    chk("fill_drained", exp_q.size(), 0);

    // Reset in the middle of a 0x81 frame
    send(8'h81);
    bus.tx_valid = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_tx", bus.tx, 1);
    chk("midrst_count", bus.fifo_count, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_ready", bus.tx_ready, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rx0 = rx_cnt;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.tx == 1'b0) n++;
    end
    chk("midrst_quiet", n, 0);
    chk("midrst_frames", rx_cnt - rx0, 0);

    // Random gaps, pointers wrap twice
    max_count = 0;
    rx0 = rx_cnt;
    for (int i = 0; i < 16; i++) begin
      send(8'($urandom_range(0, 255)));
      n = $urandom_range(0, 3);
      if (n > 0) begin
        bus.tx_valid = 1'b0;
        repeat (n) @(negedge clk);
      end
    end
    bus.tx_valid = 1'b0;
    idle_wait(n);
    chk("rand_rx", rx_cnt - rx0, 16);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_max_count", max_count <= DEPTH, 1);
    chk("rand_end_count", bus.fifo_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
